seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical strobed samples needed to capture a digit (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port iSEG, input, 7 bits: active-low segment pattern, bit0=a(top), bit1=b(top-right), bit2=c(bottom-right), bit3=d(bottom), bit4=e(bottom-left), bit5=f(top-left), bit6=g(middle).
REQ-005 SHALL have port iSEL, input, 2 bits: index of the digit currently driven on iSEG (0 = least significant).
REQ-006 SHALL have port iSTROBE, input, 1 bit: iSEG/iSEL are meaningful this cycle.
REQ-007 SHALL have port oVALUE, output, 16 bits: last published frame, digit n in bits [4n+3:4n].
REQ-008 SHALL have port oERR, output, 4 bits: per-digit flag, set when that digit's captured pattern was not a legal code.
REQ-009 SHALL have port oVALID, output, 1 bit: one-cycle pulse when oVALUE/oERR update.

Function
REQ-010 SHALL decode the legal codes 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x18->9, 0x08->A, 0x03->b, 0x46->C, 0x21->d, 0x06->E, 0x0E->F; any other pattern decodes to 0 with the digit's error bit set.
REQ-011 SHALL run a filter FSM with states IDLE, COUNT, LOCKED, a 4-bit counter cnt and a registered last sample {iSEL,iSEG}.
REQ-012 SHALL, in any state with iSTROBE=0, go to IDLE with cnt=0.
REQ-013 SHALL, in IDLE with iSTROBE=1, load the sample, set cnt=1, go to COUNT.
REQ-014 SHALL, in COUNT with iSTROBE=1 and sample equal to the last sample, increment cnt; when the new cnt equals STABLE_CYCLES, capture and go to LOCKED.
REQ-015 SHALL, in COUNT or LOCKED with iSTROBE=1 and sample different from the last sample, load the new sample, set cnt=1, go to COUNT.
REQ-016 SHALL, in LOCKED with the same sample repeated, hold without re-capture.
REQ-017 SHALL, when STABLE_CYCLES=1, capture on the cycle a new sample is loaded (IDLE entry or a sample change) and go directly to LOCKED.
REQ-018 SHALL, on capture, write the decoded nibble and error bit into bank slot iSEL and set captured-mask bit iSEL; re-capture of an already-set slot overwrites it and leaves the mask unchanged.
REQ-019 SHALL, on the edge where the mask becomes 4'b1111, register oVALUE and oERR from the bank including the digit captured on that same edge, assert oVALID for exactly the next cycle, clear the mask, and force the FSM to IDLE with cnt=0.
REQ-020 SHALL hold oVALUE and oERR unchanged between publications.
REQ-021 SHALL ignore iSTROBE during the cycle oVALID is high; filtering restarts from IDLE on the following cycle.
REQ-022 SHALL make capture latency STABLE_CYCLES strobed cycles from first sample and publication latency 1 cycle after the last capture.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set oVALUE=16'h0000, oERR=4'h0, oVALID=0, mask=0, bank=0, cnt=0, FSM=IDLE, overriding all other activity.
REQ-024 SHALL, on reset mid-frame, discard partially captured digits so that the next publication requires all four digits recaptured.

Verification
REQ-025 SHALL cover this scenario: digits 3..0 = 0x79, 0x08, 0x30, 0x0E, each held 4 strobed cycles -> oVALID pulses once, 1 cycle after the last capture, oVALUE=16'h1A3F, oERR=4'h0.
REQ-026 SHALL cover this scenario: sel0 = 0x40 held 3 cycles, then iSTROBE low 1 cycle, then 0x40 for 4 cycles -> no capture from the first run; capture on the 4th cycle of the second run.
REQ-027 SHALL cover this scenario: full frame with digit2 = 0x7F (blank) -> oVALUE[11:8]=0, oERR=4'b0100.
REQ-028 SHALL cover this scenario: sel1 captured as 0x24, then recaptured as 0x19 before the frame completes -> published oVALUE[7:4]=4.
REQ-029 SHALL cover this scenario: three digits captured, reset pulsed 1 cycle, then only sel3 captured -> no oVALID; after sel0..2 are recaptured -> one oVALID.
REQ-030 SHALL cover this scenario: STABLE_CYCLES=1, sel0 alternating 0x00/0x18 with sel1..3 stable -> a capture on each change, and oVALID once the mask fills.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Watches a multiplexed (scanned) 4-digit, active-low 7-segment display bus and
// recovers the hexadecimal value being shown. Each strobed sample {iSEL, iSEG}
// has to be seen STABLE_CYCLES times in a row before it is captured into the
// digit bank. This rejects the ghosting and settling glitches that occur while
// the scanner moves from one digit to the next. Once all four digits have been
// captured, the whole frame is published on oVALUE/oERR with a one-cycle oVALID
// pulse.
//
// Parameters
//   STABLE_CYCLES : consecutive identical strobed samples needed to capture a
//                   digit (1..15)
//
// Ports
//   clk     in   1  clock, all state updates on the rising edge
//   reset   in   1  synchronous, active-high reset
//   iSEG    in   7  active-low segments, bit0=a .. bit5=f, bit6=g
//   iSEL    in   2  index of the digit currently on iSEG (0 = least significant)
//   iSTROBE in   1  iSEG/iSEL are meaningful this cycle
//   oVALUE  out 16  last published frame, digit n in bits [4n+3:4n]
//   oERR    out  4  per-digit flag, set when the captured pattern was illegal
//   oVALID  out  1  one-cycle pulse when oVALUE/oERR update
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  iSEG,
   input  logic [1:0]  iSEL,
   input  logic        iSTROBE,
   output logic [15:0] oVALUE,
   output logic [3:0]  oERR,
   output logic        oVALID
);

   localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);
   // With a threshold of one, the first sighting of a sample is already stable.
   localparam bit LP_INSTANT = (STABLE_CYCLES == 1);

   typedef enum logic [1:0] {
      StIdle,
      StCount,
      StLocked
   } state_t;

   // Filter state
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [8:0]  r_last;

   // Digit bank and the set of slots captured in the current frame
   logic [15:0] r_bank;
   logic [3:0]  r_bank_err;
   logic [3:0]  r_mask;

   // Published outputs
   logic [15:0] r_value;
   logic [3:0]  r_err;
   logic        r_valid;

   // Next-state and decode signals
   state_t      w_state_d;
   logic [3:0]  w_cnt_d;
   logic [8:0]  w_last_d;
   logic [15:0] w_bank_d;
   logic [3:0]  w_bank_err_d;
   logic [3:0]  w_mask_set;
   logic [3:0]  w_mask_d;
   logic        w_capture;
   logic        w_publish;
   logic [8:0]  w_sample;
   logic        w_same;
   logic [3:0]  w_cnt_inc;
   logic [3:0]  w_nib;
   logic        w_bad;

   assign w_sample  = {iSEL, iSEG};
   assign w_same    = (w_sample == r_last);
   assign w_cnt_inc = r_cnt + 4'd1;

   // -------------------------------------------------------------------------
   // Segment pattern to hex nibble. Unknown patterns read as 0 and raise the
   // digit's error flag.
   // -------------------------------------------------------------------------
   always_comb begin
      w_nib = 4'h0;
      w_bad = 1'b0;
      case (iSEG)
         7'h40:   w_nib = 4'h0;
         7'h79:   w_nib = 4'h1;
         7'h24:   w_nib = 4'h2;
         7'h30:   w_nib = 4'h3;
         7'h19:   w_nib = 4'h4;
         7'h12:   w_nib = 4'h5;
         7'h02:   w_nib = 4'h6;
         7'h78:   w_nib = 4'h7;
         7'h00:   w_nib = 4'h8;
         7'h18:   w_nib = 4'h9;
         7'h08:   w_nib = 4'hA;
         7'h03:   w_nib = 4'hB;
         7'h46:   w_nib = 4'hC;
         7'h21:   w_nib = 4'hD;
         7'h06:   w_nib = 4'hE;
         7'h0E:   w_nib = 4'hF;
         default: w_bad = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // Stability filter, capture and frame assembly
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_last_d     = r_last;
      w_capture    = 1'b0;
      w_bank_d     = r_bank;
      w_bank_err_d = r_bank_err;
      w_mask_set   = r_mask;
      w_mask_d     = r_mask;
      w_publish    = 1'b0;

      if (r_valid || !iSTROBE) begin
         // The publish cycle is dead time, so the filter always restarts cleanly.
         w_state_d = StIdle;
         w_cnt_d   = 4'd0;
      end else begin
         case (r_state)
            StIdle: begin
               w_last_d  = w_sample;
               w_cnt_d   = 4'd1;
               w_state_d = LP_INSTANT ? StLocked : StCount;
               w_capture = LP_INSTANT;
            end
            StCount: begin
               if (w_same) begin
                  w_cnt_d = w_cnt_inc;
                  if (w_cnt_inc == LP_STABLE) begin
                     w_capture = 1'b1;
                     w_state_d = StLocked;
                  end
               end else begin
                  w_last_d  = w_sample;
                  w_cnt_d   = 4'd1;
                  w_state_d = LP_INSTANT ? StLocked : StCount;
                  w_capture = LP_INSTANT;
               end
            end
            StLocked: begin
               // A repeated sample is held without being captured again.
               if (!w_same) begin
                  w_last_d  = w_sample;
                  w_cnt_d   = 4'd1;
                  w_state_d = LP_INSTANT ? StLocked : StCount;
                  w_capture = LP_INSTANT;
               end
            end
            default: begin
               w_state_d = StIdle;
               w_cnt_d   = 4'd0;
            end
         endcase
      end

      if (w_capture) begin
         w_bank_d[{iSEL, 2'b00} +: 4] = w_nib;
         w_bank_err_d[iSEL]           = w_bad;
         w_mask_set[iSEL]             = 1'b1;
      end

      // The mask only reaches all-ones on the edge that captures the last digit.
      w_publish = w_capture && (w_mask_set == 4'hF);
      w_mask_d  = w_publish ? 4'h0 : w_mask_set;

      if (w_publish) begin
         w_state_d = StIdle;
         w_cnt_d   = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_cnt      <= 4'd0;
         r_last     <= 9'd0;
         r_bank     <= 16'h0000;
         r_bank_err <= 4'h0;
         r_mask     <= 4'h0;
         r_value    <= 16'h0000;
         r_err      <= 4'h0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_last     <= w_last_d;
         r_bank     <= w_bank_d;
         r_bank_err <= w_bank_err_d;
         r_mask     <= w_mask_d;
         r_valid    <= w_publish;
         if (w_publish) begin
            // Taken from the next-bank value so the final digit is included.
            r_value <= w_bank_d;
            r_err   <= w_bank_err_d;
         end
      end
   end

   assign oVALUE = r_value;
   assign oERR   = r_err;
   assign oVALID = r_valid;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Two instances: dut0 uses the default threshold (4), dut1 uses a threshold
// of 1. Each expected frame is queued together with the cycle in which its
// oVALID pulse must appear. In every other cycle, oVALID must stay low.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  err;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [6:0]  seg0, seg1;
   logic [1:0]  sel0, sel1;
   logic        stb0, stb1;
   logic [15:0] val0, val1;
   logic [3:0]  err0, err1;
   logic        v0, v1;

   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   seg_scan_decoder #(.STABLE_CYCLES(4)) dut0 (
      .clk     (clk),
      .reset   (reset),
      .iSEG    (seg0),
      .iSEL    (sel0),
      .iSTROBE (stb0),
      .oVALUE  (val0),
      .oERR    (err0),
      .oVALID  (v0)
   );

   seg_scan_decoder #(.STABLE_CYCLES(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .iSEG    (seg1),
      .iSEL    (sel1),
      .iSTROBE (stb1),
      .oVALUE  (val1),
      .oERR    (err1),
      .oVALID  (v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
         e0 = q0.pop_front();
         n_cmp += 3;
         assert (v0 === 1'b1) else begin
            n_fail++; $error("FAIL valid0 cyc=%0d observed=%b expected=1", cyc, v0);
         end
         assert (val0 === e0.val) else begin
            n_fail++; $error("FAIL value0 observed=%h expected=%h", val0, e0.val);
         end
         assert (err0 === e0.err) else begin
            n_fail++; $error("FAIL err0 observed=%b expected=%b", err0, e0.err);
         end
      end else begin
         n_cmp++;
         assert (v0 === 1'b0) else begin
            n_fail++; $error("FAIL spurious_valid0 cyc=%0d observed=%b expected=0", cyc, v0);
         end
      end
   end

   always @(negedge clk) begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
         e1 = q1.pop_front();
         n_cmp += 3;
         assert (v1 === 1'b1) else begin
            n_fail++; $error("FAIL valid1 cyc=%0d observed=%b expected=1", cyc, v1);
         end
         assert (val1 === e1.val) else begin
            n_fail++; $error("FAIL value1 observed=%h expected=%h", val1, e1.val);
         end
         assert (err1 === e1.err) else begin
            n_fail++; $error("FAIL err1 observed=%b expected=%b", err1, e1.err);
         end
      end else begin
         n_cmp++;
         assert (v1 === 1'b0) else begin
            n_fail++; $error("FAIL spurious_valid1 cyc=%0d observed=%b expected=0", cyc, v1);
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit u, input logic stb, input logic [1:0] sel,
                        input logic [6:0] seg);
      @(posedge clk);
      #1;
      if (!u) begin
         stb0 = stb; sel0 = sel; seg0 = seg; stb1 = 1'b0;
      end else begin
         stb1 = stb; sel1 = sel; seg1 = seg; stb0 = 1'b0;
      end
   endtask

   // The publication is expected one cycle after the capturing edge of the last drive.
   task automatic push(input bit u, input logic [15:0] val, input logic [3:0] err);
      exp_t e;
      e.val = val;
      e.err = err;
      e.cyc = cyc + 1;
      if (!u) q0.push_back(e);
      else    q1.push_back(e);
   endtask

   task automatic hold(input bit u, input logic [1:0] sel, input logic [6:0] seg, input int n,
                       input bit pub, input logic [15:0] val, input logic [3:0] err);
      for (int i = 0; i < n; i++) begin
         drive(u, 1'b1, sel, seg);
         if (pub && i == n - 1) push(u, val, err);
      end
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 7'h7F);
   endtask

   initial begin
      reset = 1'b1;
      stb0 = 1'b0; sel0 = 2'd0; seg0 = 7'h7F;
      stb1 = 1'b0; sel1 = 2'd0; seg1 = 7'h7F;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_value0", val0, 16'h0000);
      chk("reset_err0", {12'h0, err0}, 16'h0000);
      chk("reset_value1", val1, 16'h0000);
      chk("reset_err1", {12'h0, err1}, 16'h0000);

      // Basic frame, digits 3..0 = 1, A, 3, F
      hold(0, 2'd3, 7'h79, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd2, 7'h08, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd1, 7'h30, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd0, 7'h0E, 4, 1, 16'h1A3F, 4'h0);
      gap(4);
      chk("hold_value0", val0, 16'h1A3F);
      chk("hold_err0", {12'h0, err0}, 16'h0000);

      // An interrupted run must not capture; the clean run of four captures on its 4th cycle.
      hold(0, 2'd3, 7'h19, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd2, 7'h12, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd1, 7'h02, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd0, 7'h40, 3, 0, 16'h0, 4'h0);
      gap(1);
      hold(0, 2'd0, 7'h40, 4, 1, 16'h4560, 4'h0);
      gap(1);

      // Blank digit 2 is illegal
      hold(0, 2'd3, 7'h78, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd2, 7'h7F, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd1, 7'h00, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd0, 7'h18, 4, 1, 16'h7089, 4'b0100);
      gap(1);

      // Digit 1 recaptured before the frame completes
      hold(0, 2'd1, 7'h24, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd3, 7'h46, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd1, 7'h19, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd2, 7'h21, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd0, 7'h06, 4, 1, 16'hCD4E, 4'h0);
      gap(1);

      // Mid-frame reset discards the partial frame
      hold(0, 2'd0, 7'h03, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd1, 7'h0E, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd2, 7'h08, 4, 0, 16'h0, 4'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      stb0  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset_value0", val0, 16'h0000);
      chk("midreset_err0", {12'h0, err0}, 16'h0000);
      hold(0, 2'd3, 7'h79, 4, 0, 16'h0, 4'h0);
      gap(4);
      hold(0, 2'd0, 7'h40, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd1, 7'h79, 4, 0, 16'h0, 4'h0);
      hold(0, 2'd2, 7'h24, 4, 1, 16'h1210, 4'h0);
      gap(2);

      // Threshold of one: every sample change on digit 0 is a capture
      hold(1, 2'd0, 7'h00, 2, 0, 16'h0, 4'h0);
      hold(1, 2'd0, 7'h18, 2, 0, 16'h0, 4'h0);
      hold(1, 2'd0, 7'h00, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd0, 7'h18, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd1, 7'h79, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd2, 7'h24, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd3, 7'h30, 1, 1, 16'h3219, 4'h0);
      gap(1);
      hold(1, 2'd1, 7'h79, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd2, 7'h24, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd3, 7'h30, 1, 0, 16'h0, 4'h0);
      hold(1, 2'd0, 7'h00, 1, 1, 16'h3218, 4'h0);
      gap(4);

      n_cmp++;
      assert (q0.size() == 0 && q1.size() == 0) else begin
         n_fail++;
         $error("FAIL pending_frames observed=%0d expected=0", q0.size() + q1.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
